// File: rtl/prod_ctrl.sv
// rtl/prod_ctrl.sv - N-channel producer/buffer flow controller with start arbitration and word count.
// Optional auto-stop at MAX_WORDS accepted words: define PROD_CTRL_AUTOSTOP_EN.
module prod_ctrl #(
    parameter int N_CH      = 2,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 100,
    parameter int SEL_W     = $clog2(N_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          start,
    input  logic                     stop,
    input  logic                     buffer_full,
    input  logic                     buffer_empty,
    input  logic                     data_2_valid,
    input  logic [N_CH-1:0]          prod_valid,
    input  logic [N_CH*DATA_W-1:0]   prod_data,
    output logic [N_CH-1:0]          prod_en,
    output logic                     data_1_en,
    output logic [DATA_W-1:0]        data_1,
    output logic [SEL_W-1:0]         mode,
    output logic [3:0]               led,
    output logic [15:0]              words
);

    localparam int ACT_W = $clog2(N_CH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COMM  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef PROD_CTRL_AUTOSTOP_EN
    localparam logic AUTOSTOP = 1'b1;
`else
    localparam logic AUTOSTOP = 1'b0;
`endif

    logic [1:0]       state;
    logic [ACT_W-1:0] active;
    logic [N_CH-1:0]  start_prev;
    logic             stop_prev;
    logic [N_CH-1:0]  start_edge;
    logic             stop_edge;
    logic [ACT_W-1:0] first_edge;
    logic             limit_hit;

    assign start_edge = start & ~start_prev;
    assign stop_edge  = stop & ~stop_prev;

    // Walk from the top down so the lowest set edge wins.
    always_comb begin
        first_edge = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (start_edge[i]) first_edge = ACT_W'(i);
        end
    end

    always_comb begin
        prod_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            prod_en[i] = (state == S_COMM) && (ACT_W'(i) == active) && !buffer_full;
        end
    end

    assign data_1_en = prod_en[active] & prod_valid[active];
    assign data_1    = data_1_en ? prod_data[active*DATA_W +: DATA_W] : '0;

    // The write that reaches the limit is the last one; the state leaves COMM on that edge.
    assign limit_hit = AUTOSTOP && data_1_en && (words == 16'(MAX_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            active     <= '0;
            start_prev <= '0;
            stop_prev  <= 1'b0;
            words      <= '0;
        end else begin
            start_prev <= start;
            stop_prev  <= stop;
            if (data_1_en && words != 16'hFFFF) words <= words + 16'd1;
            case (state)
                S_IDLE: begin
                    if (|start_edge) begin
                        state  <= S_COMM;
                        active <= first_edge;
                        words  <= '0;
                    end
                end
                S_COMM: begin
                    if (stop_edge || limit_hit) state <= S_DRAIN;
                    else if (buffer_full)       state <= S_WAIT;
                end
                S_WAIT: begin
                    if (stop_edge)         state <= S_DRAIN;
                    else if (!buffer_full) state <= S_COMM;
                end
                default: begin
                    if (buffer_empty && !data_2_valid) state <= S_IDLE;
                end
            endcase
        end
    end

    assign mode = (state == S_COMM || state == S_WAIT) ? SEL_W'(active) + SEL_W'(1) : '0;

    always_comb begin
        case (state)
            S_IDLE:  led = 4'b0001;
            S_COMM:  led = 4'b0010;
            S_WAIT:  led = 4'b0100;
            default: led = 4'b1000;
        endcase
    end

endmodule

// File: doc/prod_ctrl.md
# prod_ctrl

Parametrised producer/buffer flow controller for N_CH data producers feeding one shared buffer wrapper and display. It is the generalised successor of the two-producer controller FSM: N_CH producers, a configurable data width, built-in button edge detection, a lowest-index arbiter for simultaneous starts, and a saturating accepted-word counter. It sits between the producer modules, the buffer wrapper and the display module, in the clk domain.

## Interface
- N_CH, 2, number of producer channels (2..8)
- DATA_W, 16, producer/buffer data width
- MAX_WORDS, 100, auto-stop word limit (used only with PROD_CTRL_AUTOSTOP_EN; 1..2^16-1)
- SEL_W, $clog2(N_CH+1), width of mode output (derived, not overridden)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  N_CH  per-channel start button levels (debounced, synchronous to clk)
- stop  in  1  stop button level, shared by all channels
- buffer_full  in  1  buffer cannot accept a word this cycle
- buffer_empty  in  1  buffer holds no words
- data_2_valid  in  1  consumer side still presenting a word
- prod_valid  in  N_CH  producer i has a word on its slice of prod_data
- prod_data  in  N_CH*DATA_W  producer i word on bits [i*DATA_W +: DATA_W]
- prod_en  out  N_CH  enable to producer i
- data_1_en  out  1  write strobe to buffer
- data_1  out  DATA_W  word to buffer
- mode  out  SEL_W  active channel+1 in COMM/WAIT, else 0 (display source select)
- led  out  4  one-hot state: [0] IDLE, [1] COMM, [2] WAIT, [3] DRAIN
- words  out  16  accepted-word count of current session

## Operation
- Edge detection: prev register per start bit and for stop. Edge = level & ~prev. prev resets to 0, so an input already high at reset release gives one edge on the first clock.
- States:
  - IDLE: any start edge -> COMM. The active channel is set to the lowest index with an edge, and words is cleared. stop is ignored.
  - COMM: a stop edge -> DRAIN; this has priority. Otherwise buffer_full -> WAIT.
  - WAIT: a stop edge -> DRAIN; this has priority. Otherwise !buffer_full -> COMM.
  - DRAIN: buffer_empty & !data_2_valid -> IDLE.
- Start edges outside IDLE are ignored. The active channel is held until the next IDLE->COMM transition.
- prod_en[i] = (state==COMM) & (i==active) & !buffer_full. All other bits are 0.
- data_1_en = prod_en[active] & prod_valid[active]. This is combinational, with a single-cycle write per accepted word.
- data_1 = prod_data slice of active channel when data_1_en, else 0.
- words increments on every data_1_en cycle and saturates at 16'hFFFF.
- Outputs other than data_1/data_1_en/prod_en are derived from registered state only.

## Timing
- Reset values: state IDLE (led=4'b0001), active=0, words=0, mode=0, prod_en=0, data_1_en=0, data_1=0.
- A button edge sampled at clock edge k changes the state at edge k. New led/mode are visible after edge k.
- A full->WAIT transition takes 1 cycle. In the cycle buffer_full is high, prod_en and data_1_en are already 0 (combinational gate), so no write is issued into a full buffer.
- WAIT->COMM occurs at the first edge with buffer_full=0. prod_en reasserts in the following cycle.
- DRAIN exit occurs at the first edge with buffer_empty=1 and data_2_valid=0.
- Async rst mid-session: all state is cleared immediately, and the buffer contents are not this block's concern.

## Configuration
- PROD_CTRL_AUTOSTOP_EN defined:
  - In COMM, an accepted write that makes words == MAX_WORDS forces COMM -> DRAIN at that edge. This has the same priority as a stop edge.
  - No further prod_en is issued.
- PROD_CTRL_AUTOSTOP_EN undefined:
  - No limit applies, and MAX_WORDS is ignored.
  - Sessions end only via stop.

## Test plan
- Reset, start[1] edge with N_CH=2, prod_valid=2'b10, 5 cycles -> led 0001->0010, mode=2, data_1 = channel-1 data, words=5.
- Simultaneous start=3'b110 edge (N_CH=3) -> active=1, mode=2; later start[0] edge during COMM ignored.
- buffer_full raised in COMM for 3 cycles -> data_1_en=0 same cycle, led=0100 for 3 cycles, back to 0010 and writes resume.
- stop edge coinciding with buffer_full -> DRAIN (led=1000), not WAIT; stays until buffer_empty=1 and data_2_valid=0, then IDLE.
- PROD_CTRL_AUTOSTOP_EN, MAX_WORDS=4, continuous valid -> exactly 4 writes, words=4, DRAIN entered on 4th write edge.
- Async rst asserted mid-COMM -> led=0001, words=0, prod_en=0 immediately without waiting for clk.
